// File: rtl/mux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mux_rr_scheduler
//
// Round-robin scheduler that shares one 4-to-1 select datapath between four
// requesters. It picks the next requester after the last one served, holds
// the grant for at most HOLD_CYCLES clocks, and registers the selected data
// word for the downstream capture stage.
//
// Parameters
//   WIDTH        bit width of each in_dataN and of out_data
//   HOLD_CYCLES  maximum grant length in clk cycles (>= 1)
//
// Ports
//   clk        rising-edge system clock
//   reset_n    asynchronous active-low reset
//   req        req[k]=1 : requester k wants the datapath
//   in_data0-3 data words from requesters 0..3
//   lock       keeps the current grant past slot expiry
//              (present only when MUX_SCHED_LOCK_EN is defined)
//   select     registered index of the current/last granted requester
//   grant      registered one-hot grant, zero while idle
//   busy       registered, high while a grant is active
//   valid      registered, out_data holds a word sampled during a grant
//   out_data   registered copy of the selected in_dataN
//
// Build option
//   MUX_SCHED_LOCK_EN : adds the lock input and the expiry-suppression logic.
// ---------------------------------------------------------------------------
module mux_rr_scheduler #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
`ifdef MUX_SCHED_LOCK_EN
    input  logic             lock,
`endif
    output logic [1:0]       select,
    output logic [3:0]       grant,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_ptr_q, last_ptr_d;
    logic [1:0]       select_q, select_d;
    logic [3:0]       grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             winFound;
    logic [1:0]       winIdx;
    logic [1:0]       cand;
    logic [WIDTH-1:0] selData;
    logic             lockHold;
    logic             slotExpired;
    logic             releaseNow;

    // Round-robin search: start one past the last served requester and
    // wrap; offset 4 folds back onto last_ptr itself so it is checked last.
    always_comb begin
        winFound = 1'b0;
        winIdx   = 2'd0;
        cand     = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_ptr_q + 2'(i);
            if (!winFound && req[cand]) begin
                winFound = 1'b1;
                winIdx   = cand;
            end
        end
    end

    always_comb begin
        case (select_q)
            2'd0:    selData = in_data0;
            2'd1:    selData = in_data1;
            2'd2:    selData = in_data2;
            default: selData = in_data3;
        endcase
    end

`ifdef MUX_SCHED_LOCK_EN
    assign lockHold = lock & req[select_q];
`else
    assign lockHold = 1'b0;
`endif

    // A grant ends when its owner drops the request, or when the slot is
    // used up and no lock is holding it open.
    assign slotExpired = (cnt_q == CNT_LAST);
    assign releaseNow  = !req[select_q] || (slotExpired && !lockHold);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_ptr_q <= 2'd3;
            select_q   <= 2'd0;
            grant_q    <= 4'd0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_ptr_q <= last_ptr_d;
            select_q   <= select_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (winFound)   state_d = GRANT;
            GRANT:   if (releaseNow) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs. While locked at expiry the
    // counter saturates, so dropping lock releases on the following edge.
    always_comb begin
        cnt_d      = cnt_q;
        last_ptr_d = last_ptr_q;
        select_d   = select_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (winFound) begin
                    select_d = winIdx;
                    grant_d  = 4'b0001 << winIdx;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            GRANT: begin
                valid_d    = 1'b1;
                out_data_d = selData;
                if (releaseNow) begin
                    grant_d    = 4'd0;
                    busy_d     = 1'b0;
                    last_ptr_d = select_q;
                    cnt_d      = '0;
                end else if (!slotExpired) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign select   = select_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_scheduler
//
// Directed bench for mux_rr_scheduler (WIDTH=4, HOLD_CYCLES=4). A table of
// per-edge vectors walks through single-requester slots, full rotation with
// wrap, data capture, early release and the search start point; hand
// sequences cover asynchronous reset mid-grant and, when built with
// MUX_SCHED_LOCK_EN, the lock extension.
// ---------------------------------------------------------------------------
module tb_mux_rr_scheduler;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] in_data0, in_data1, in_data2, in_data3;
    logic       lock;
    logic [1:0] select;
    logic [3:0] grant;
    logic       busy;
    logic       valid;
    logic [3:0] out_data;

    int compared;
    int mismatched;

    typedef struct {
        logic [3:0] req;
        logic [3:0] d2;
        logic [3:0] expGrant;
        logic [1:0] expSel;
        logic       expBusy;
        logic       expValid;
        logic [3:0] expOut;
    } vec_t;

    vec_t vecs [31];

    mux_rr_scheduler #(.WIDTH(4), .HOLD_CYCLES(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .in_data0 (in_data0),
        .in_data1 (in_data1),
        .in_data2 (in_data2),
        .in_data3 (in_data3),
`ifdef MUX_SCHED_LOCK_EN
        .lock     (lock),
`endif
        .select   (select),
        .grant    (grant),
        .busy     (busy),
        .valid    (valid),
        .out_data (out_data)
    );

    // 10 ns clock; outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] g, input logic [1:0] s,
                               input logic b, input logic v, input logic [3:0] o);
        checkField({tag, ".grant"},    int'(grant),    int'(g));
        checkField({tag, ".select"},   int'(select),   int'(s));
        checkField({tag, ".busy"},     int'(busy),     int'(b));
        checkField({tag, ".valid"},    int'(valid),    int'(v));
        checkField({tag, ".out_data"}, int'(out_data), int'(o));
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d2);
        req      = r;
        in_data2 = d2;
    endtask

    task automatic setVec(input int n, input logic [3:0] r, input logic [3:0] d2,
                          input logic [3:0] g, input logic [1:0] s, input logic b,
                          input logic v, input logic [3:0] o);
        vecs[n] = '{r, d2, g, s, b, v, o};
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        in_data0   = 4'h1;
        in_data1   = 4'h2;
        in_data2   = 4'hA;
        in_data3   = 4'h3;
        lock       = 1'b0;
        req        = 4'hF;
        reset_n    = 1'b0;

        // Table: inputs applied before an edge, expectations after it.
        // Single requester 0: four grant cycles, one gap, re-grant, drop.
        setVec( 0, 4'h1, 4'hA, 4'h1, 2'd0, 1, 0, 4'h0);
        setVec( 1, 4'h1, 4'hA, 4'h1, 2'd0, 1, 1, 4'h1);
        setVec( 2, 4'h1, 4'hA, 4'h1, 2'd0, 1, 1, 4'h1);
        setVec( 3, 4'h1, 4'hA, 4'h1, 2'd0, 1, 1, 4'h1);
        setVec( 4, 4'h1, 4'hA, 4'h0, 2'd0, 0, 1, 4'h1);
        setVec( 5, 4'h1, 4'hA, 4'h1, 2'd0, 1, 0, 4'h1);
        setVec( 6, 4'h1, 4'hA, 4'h1, 2'd0, 1, 1, 4'h1);
        setVec( 7, 4'h0, 4'hA, 4'h0, 2'd0, 0, 1, 4'h1);
        setVec( 8, 4'h0, 4'hA, 4'h0, 2'd0, 0, 0, 4'h1);
        // All four requesting: rotate 1, 2, 3 and wrap to 0.
        setVec( 9, 4'hF, 4'hA, 4'h2, 2'd1, 1, 0, 4'h1);
        setVec(10, 4'hF, 4'hA, 4'h2, 2'd1, 1, 1, 4'h2);
        setVec(11, 4'hF, 4'hA, 4'h2, 2'd1, 1, 1, 4'h2);
        setVec(12, 4'hF, 4'hA, 4'h2, 2'd1, 1, 1, 4'h2);
        setVec(13, 4'hF, 4'hA, 4'h0, 2'd1, 0, 1, 4'h2);
        setVec(14, 4'hF, 4'hA, 4'h4, 2'd2, 1, 0, 4'h2);
        setVec(15, 4'hF, 4'hA, 4'h4, 2'd2, 1, 1, 4'hA);
        setVec(16, 4'hF, 4'h5, 4'h4, 2'd2, 1, 1, 4'h5);
        setVec(17, 4'hF, 4'h5, 4'h4, 2'd2, 1, 1, 4'h5);
        setVec(18, 4'hF, 4'h5, 4'h0, 2'd2, 0, 1, 4'h5);
        setVec(19, 4'hF, 4'hA, 4'h8, 2'd3, 1, 0, 4'h5);
        setVec(20, 4'hF, 4'hA, 4'h8, 2'd3, 1, 1, 4'h3);
        setVec(21, 4'hF, 4'hA, 4'h8, 2'd3, 1, 1, 4'h3);
        setVec(22, 4'hF, 4'hA, 4'h8, 2'd3, 1, 1, 4'h3);
        setVec(23, 4'hF, 4'hA, 4'h0, 2'd3, 0, 1, 4'h3);
        setVec(24, 4'hF, 4'hA, 4'h1, 2'd0, 1, 0, 4'h3);
        // Early drop, then requester 2 dropped after two cycles; the next
        // search starts at 3 so 3 beats 0.
        setVec(25, 4'h0, 4'hA, 4'h0, 2'd0, 0, 1, 4'h1);
        setVec(26, 4'h0, 4'hA, 4'h0, 2'd0, 0, 0, 4'h1);
        setVec(27, 4'h4, 4'hA, 4'h4, 2'd2, 1, 0, 4'h1);
        setVec(28, 4'h4, 4'hA, 4'h4, 2'd2, 1, 1, 4'hA);
        setVec(29, 4'h9, 4'hA, 4'h0, 2'd2, 0, 1, 4'hA);
        setVec(30, 4'h9, 4'hA, 4'h8, 2'd3, 1, 0, 4'hA);

        // Reset held with all requests active: outputs must be cleared.
        #1;
        checkOutput("reset0", 4'h0, 2'd0, 0, 0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("resetHeld", 4'h0, 2'd0, 0, 0, 4'h0);
        req     = 4'h0;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idleNoReq", 4'h0, 2'd0, 0, 0, 4'h0);

        for (int i = 0; i < 31; i++) begin
            applyStimulus(vecs[i].req, vecs[i].d2);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i].expGrant, vecs[i].expSel,
                        vecs[i].expBusy, vecs[i].expValid, vecs[i].expOut);
        end

        // Asynchronous reset in the middle of a grant clears at once.
        applyStimulus(4'hF, 4'hA);
        reset_n = 1'b0;
        #1;
        checkOutput("asyncReset", 4'h0, 2'd0, 0, 0, 4'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("postReset", 4'h1, 2'd0, 1, 0, 4'h0);

`ifdef MUX_SCHED_LOCK_EN
        // Lock keeps requester 0 past expiry; dropping it releases next edge.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        applyStimulus(4'h3, 4'hA);
        lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkField($sformatf("lockGrant%0d", i), int'(grant), 4'h1);
        end
        lock = 1'b0;
        @(negedge clk);
        checkOutput("lockRelease", 4'h0, 2'd0, 0, 1, 4'h1);
        @(negedge clk);
        checkOutput("lockNext", 4'h2, 2'd1, 1, 0, 4'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
